vga_text_render: RTL and testbench

- Downstream consumer of the 1024x768@60 VGA timing generator. Takes its HS, VS, countX and countY.
- Renders an 8x16-pixel text mode: 128 columns x 48 rows.
- Reads a character/attribute RAM and a font ROM, both external and synchronous.
- Outputs 12-bit RGB plus sync signals, all delayed by the same 3-cycle pipeline so the monitor sees them aligned.

---
 rtl/vga_text_render_if.sv | 22 ++
 rtl/vga_text_render.sv | 179 +++++++++++++++++
 tb/tb_vga_text_render.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_render_if.sv
// Memory-side bus of the text renderer: character/attribute RAM and font ROM.
// The renderer owns the addresses; the memories return data one cycle after it.
interface vga_text_render_if;
    logic [12:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;

    modport master (
        output char_addr,
        output font_addr,
        input  char_data,
        input  font_data
    );

    modport slave (
        input  char_addr,
        input  font_addr,
        output char_data,
        output font_data
    );
endinterface

// File: rtl/vga_text_render.sv
// 128x48 text-mode renderer (8x16 glyphs) behind the 1024x768@60 timing generator.
// Four register stages give RGB and syncs a common 3-cycle delay from the sampled inputs.
module vga_text_render #(
    parameter int BLINK_FRAMES = 32,
    parameter int ACTIVE_W     = 1024,
    parameter int ACTIVE_H     = 768
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      HS,
    input  logic                      VS,
    input  logic [10:0]               countX,
    input  logic [9:0]                countY,
    input  logic                      cursor_en,
    input  logic [6:0]                cursor_col,
    input  logic [5:0]                cursor_row,
    vga_text_render_if.master         mem,
    output logic                      HS_out,
    output logic                      VS_out,
    output logic [11:0]               rgb
);

    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    // blink state
    logic       prev_vs_q, prev_vs_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       blink_q, blink_d;

    // stage 1
    logic [12:0] char_addr_q, char_addr_d;
    logic [2:0]  xbit1_q, xbit1_d;
    logic [3:0]  line1_q, line1_d;
    logic        act1_q, act1_d;
    logic        cur1_q, cur1_d;
    logic        hs1_q, hs1_d;
    logic        vs1_q, vs1_d;

    // stage 2
    logic [11:0] font_addr_q, font_addr_d;
    logic [2:0]  xbit2_q, xbit2_d;
    logic        act2_q, act2_d;
    logic [3:0]  fg2_q, fg2_d;
    logic [3:0]  bg2_q, bg2_d;
    logic        hs2_q, hs2_d;
    logic        vs2_q, vs2_d;

    // stage 3 and output
    logic [11:0] rgb3_q, rgb3_d;
    logic        hs3_q, hs3_d;
    logic        vs3_q, vs3_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;

    logic        pixel;

    // Set channel bits read 0xA (0xF bright), clear ones 0x0 (0x5 bright).
    function automatic logic [11:0] palette(input logic [3:0] irgb);
        logic [3:0] lvl_on;
        logic [3:0] lvl_off;
        lvl_on  = irgb[3] ? 4'hF : 4'hA;
        lvl_off = irgb[3] ? 4'h5 : 4'h0;
        return {irgb[2] ? lvl_on : lvl_off,
                irgb[1] ? lvl_on : lvl_off,
                irgb[0] ? lvl_on : lvl_off};
    endfunction

    always_comb begin
        prev_vs_d   = VS;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (prev_vs_q && !VS) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        char_addr_d = {countY[9:4], countX[9:3]};
        xbit1_d     = countX[2:0];
        line1_d     = countY[3:0];
        act1_d      = (countX < 11'(ACTIVE_W)) && (countY < 10'(ACTIVE_H));
        // blink_q is the pre-update value, so a toggle only affects later pixels
        cur1_d      = cursor_en && blink_q
                      && (countX[9:3] == cursor_col)
                      && (countY[9:4] == cursor_row)
                      && (countY[3:0] >= 4'd14);
        hs1_d       = HS;
        vs1_d       = VS;
    end

    always_comb begin
        font_addr_d = {mem.char_data[7:0], line1_q};
        fg2_d       = mem.char_data[11:8];
        bg2_d       = mem.char_data[15:12];
        if (cur1_q) begin
            fg2_d = mem.char_data[15:12];
            bg2_d = mem.char_data[11:8];
        end
        xbit2_d = xbit1_q;
        act2_d  = act1_q;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
    end

    always_comb begin
        pixel    = mem.font_data[3'd7 - xbit2_q];
        rgb3_d   = act2_q ? palette(pixel ? fg2_q : bg2_q) : 12'h000;
        hs3_d    = hs2_q;
        vs3_d    = vs2_q;
        rgb_d    = rgb3_q;
        hs_out_d = hs3_q;
        vs_out_d = vs3_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_vs_q   <= 1'b1;
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
            char_addr_q <= 13'd0;
            xbit1_q     <= 3'd0;
            line1_q     <= 4'd0;
            act1_q      <= 1'b0;
            cur1_q      <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            font_addr_q <= 12'd0;
            xbit2_q     <= 3'd0;
            act2_q      <= 1'b0;
            fg2_q       <= 4'd0;
            bg2_q       <= 4'd0;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
            rgb3_q      <= 12'h000;
            hs3_q       <= 1'b1;
            vs3_q       <= 1'b1;
            rgb_q       <= 12'h000;
            hs_out_q    <= 1'b1;
            vs_out_q    <= 1'b1;
        end else begin
            prev_vs_q   <= prev_vs_d;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            char_addr_q <= char_addr_d;
            xbit1_q     <= xbit1_d;
            line1_q     <= line1_d;
            act1_q      <= act1_d;
            cur1_q      <= cur1_d;
            hs1_q       <= hs1_d;
            vs1_q       <= vs1_d;
            font_addr_q <= font_addr_d;
            xbit2_q     <= xbit2_d;
            act2_q      <= act2_d;
            fg2_q       <= fg2_d;
            bg2_q       <= bg2_d;
            hs2_q       <= hs2_d;
            vs2_q       <= vs2_d;
            rgb3_q      <= rgb3_d;
            hs3_q       <= hs3_d;
            vs3_q       <= vs3_d;
            rgb_q       <= rgb_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
        end
    end

    assign mem.char_addr = char_addr_q;
    assign mem.font_addr = font_addr_q;
    assign rgb           = rgb_q;
    assign HS_out        = hs_out_q;
    assign VS_out        = vs_out_q;

endmodule

// File: tb/tb_vga_text_render.sv
// Self-checking bench for vga_text_render: directed steps plus random pixels,
// checked against a pixel-level reference model through a 3-deep expectation queue.
module tb_vga_text_render;

    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic [10:0] cx = '0;
    logic [9:0]  cy = '0;
    logic        cen = 1'b0;
    logic [6:0]  ccol = '0;
    logic [5:0]  crow = '0;
    logic        hs_out;
    logic        vs_out;
    logic [11:0] rgb_o;

    logic [15:0] ram [8192];
    logic [7:0]  rom [4096];

    vga_text_render_if mem_if ();

    assign mem_if.char_data = ram[mem_if.char_addr];
    assign mem_if.font_data = rom[mem_if.font_addr];

    vga_text_render #(.BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .reset      (reset),
        .HS         (hs),
        .VS         (vs),
        .countX     (cx),
        .countY     (cy),
        .cursor_en  (cen),
        .cursor_col (ccol),
        .cursor_row (crow),
        .mem        (mem_if),
        .HS_out     (hs_out),
        .VS_out     (vs_out),
        .rgb        (rgb_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];
    int   falls;
    logic prev_vs_m;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] pal_m(input logic [3:0] c);
        logic [11:0] r;
        int lvl;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            if (c[i]) lvl = c[3] ? 15 : 10;
            else      lvl = c[3] ? 5 : 0;
            r = r | (12'(lvl) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y, input int blink);
        int col, row, line, xb;
        logic [15:0] w;
        logic [3:0]  fg, bg, t;
        logic [7:0]  bits;
        if (x >= 1024 || y >= 768) return 12'h000;
        col  = x / 8;
        row  = y / 16;
        line = y % 16;
        xb   = x % 8;
        w    = ram[row * 128 + col];
        fg   = w[11:8];
        bg   = w[15:12];
        if (cen && blink != 0 && col == int'(ccol) && row == int'(crow) && line >= 14) begin
            t = fg; fg = bg; bg = t;
        end
        bits = rom[int'(w[7:0]) * 16 + line];
        return bits[7 - xb] ? pal_m(fg) : pal_m(bg);
    endfunction

    task automatic model_reset();
        exp_t e;
        e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
        q.delete();
        repeat (3) q.push_back(e);
        falls = 0;
        prev_vs_m = 1'b1;
    endtask

    task automatic step(input int x, input int y, input logic h, input logic v);
        exp_t e;
        cx = x[10:0];
        cy = y[9:0];
        hs = h;
        vs = v;
        e.rgb = model_rgb(x, y, (falls / BF) % 2);
        e.hs  = h;
        e.vs  = v;
        q.push_back(e);
        if (prev_vs_m && !v) falls++;
        prev_vs_m = v;
        @(posedge clk);
        #1;
        if (q.size() >= 4) begin
            e = q.pop_front();
            chk("rgb", {4'h0, rgb_o}, {4'h0, e.rgb});
            chk("HS_out", {15'h0, hs_out}, {15'h0, e.hs});
            chk("VS_out", {15'h0, vs_out}, {15'h0, e.vs});
        end
    endtask

    task automatic flush3();
        repeat (3) step(0, 0, 1'b1, 1'b1);
    endtask

    task automatic vs_pulse();
        step(1100, 780, 1'b1, 1'b0);
        step(1100, 780, 1'b1, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        model_reset();

        // asynchronous reset, no clock edge yet
        #2 reset = 1'b1;
        #1;
        chk("rst_rgb", {4'h0, rgb_o}, 16'h0000);
        chk("rst_hs", {15'h0, hs_out}, 16'h0001);
        chk("rst_vs", {15'h0, vs_out}, 16'h0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // HS delay of exactly three edges
        step(1100, 780, 1'b0, 1'b1);
        step(1100, 780, 1'b1, 1'b1);
        step(1100, 780, 1'b1, 1'b1);
        chk("hs_early", {15'h0, hs_out}, 16'h0001);
        step(1100, 780, 1'b1, 1'b1);
        chk("hs_k3", {15'h0, hs_out}, 16'h0000);

        // worked example: bg=1 -> 00A, fg=E -> FF5
        ram[2 * 128 + 2]   = 16'h1E41;
        rom[16'h41 * 16 + 3] = 8'b0010_0000;
        step(16, 35, 1'b1, 1'b1);
        chk("char_addr", {3'h0, mem_if.char_addr}, 16'h0102);
        step(18, 35, 1'b1, 1'b1);
        chk("font_addr", {4'h0, mem_if.font_addr}, 16'h0413);
        step(0, 0, 1'b1, 1'b1);
        step(0, 0, 1'b1, 1'b1);
        chk("ex_bg", {4'h0, rgb_o}, 16'h000A);
        step(0, 0, 1'b1, 1'b1);
        chk("ex_fg", {4'h0, rgb_o}, 16'h0FF5);

        // blanking with all-ones memory contents
        ram[0] = 16'hFFFF;
        rom[16'hFF * 16 + 10] = 8'hFF;
        ram[48 * 128 + 5] = 16'hFFFF;
        rom[16'hFF * 16 + 12] = 8'hFF;
        step(1030, 10, 1'b1, 1'b1);
        flush3();
        chk("blank_x", {4'h0, rgb_o}, 16'h0000);
        step(40, 780, 1'b1, 1'b1);
        flush3();
        chk("blank_y", {4'h0, rgb_o}, 16'h0000);

        // cursor at (5,3); cell glyph all background, bg=1 fg=E
        ram[3 * 128 + 5] = 16'h1E80;
        for (int l = 0; l < 16; l++) rom[16'h80 * 16 + l] = 8'h00;
        cen = 1'b1; ccol = 7'd5; crow = 6'd3;
        step(43, 62, 1'b1, 1'b1);
        flush3();
        chk("cur_blink0", {4'h0, rgb_o}, 16'h000A);
        vs_pulse();
        vs_pulse();
        step(43, 62, 1'b1, 1'b1);
        flush3();
        chk("cur_l14", {4'h0, rgb_o}, 16'h0FF5);
        step(44, 63, 1'b1, 1'b1);
        flush3();
        chk("cur_l15", {4'h0, rgb_o}, 16'h0FF5);
        step(43, 61, 1'b1, 1'b1);
        flush3();
        chk("cur_l13", {4'h0, rgb_o}, 16'h000A);
        for (int y = 48; y < 64; y++)
            for (int x = 40; x < 48; x++)
                step(x, y, 1'b1, 1'b1);
        vs_pulse();
        vs_pulse();
        step(43, 62, 1'b1, 1'b1);
        flush3();
        chk("cur_off", {4'h0, rgb_o}, 16'h000A);

        // cursor disabled while blink phase is on
        vs_pulse();
        vs_pulse();
        cen = 1'b0;
        step(43, 62, 1'b1, 1'b1);
        flush3();
        chk("cen0", {4'h0, rgb_o}, 16'h000A);

        // random pixels, syncs and cursor settings; half aimed at the cursor cell
        for (int n = 0; n < 3000; n++) begin
            int x, y;
            if (n % 64 == 0) begin
                cen  = 1'($urandom);
                ccol = 7'($urandom);
                crow = 6'($urandom);
            end
            if ($urandom_range(1, 0) == 1) begin
                x = int'(ccol) * 8 + int'($urandom_range(7, 0));
                y = int'(crow) * 16 + int'($urandom_range(15, 12));
            end else begin
                x = int'($urandom_range(1343, 0));
                y = int'($urandom_range(805, 0));
            end
            step(x, y, 1'($urandom), 1'($urandom));
        end

        // free-running lines around the vertical sync
        cen = 1'b0;
        for (int y = 766; y < 778; y++)
            for (int x = 0; x < 1344; x++)
                step(x, y, !(x >= 1048 && x < 1184), !(y >= 771 && y < 777));

        // reset during active video with blink phase on
        cen = 1'b1; ccol = 7'd5; crow = 6'd3;
        for (int k = 0; k < 2 && ((falls / BF) % 2) == 0; k++) vs_pulse();
        step(43, 62, 1'b1, 1'b1);
        step(44, 62, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_rgb", {4'h0, rgb_o}, 16'h0000);
        chk("mid_rst_hs", {15'h0, hs_out}, 16'h0001);
        chk("mid_rst_vs", {15'h0, vs_out}, 16'h0001);
        #2 reset = 1'b0;
        model_reset();
        step(43, 62, 1'b1, 1'b1);
        flush3();
        chk("rst_blink", {4'h0, rgb_o}, 16'h000A);
        for (int y = 48; y < 64; y++)
            for (int x = 40; x < 48; x++)
                step(x, y, 1'b1, 1'b1);
        flush3();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
